dct1d_rr_sched: RTL

- Shares one combinational 8-point 1D DCT core among NREQ requesters.
- Round-robin arbitration; operand and result are registered on either side of the core.
- Each requester offers one 64-bit packed row (8 × signed 8-bit samples).
- Results come back on a single tagged 144-bit output stream (8 × signed 18-bit coefficients) with backpressure.
- Sits between the row-producing front end and the downstream quantiser/transpose logic.

---
 rtl/dct1d_pkg.sv | 16 +
 rtl/dct1d_rr_sched_if.sv | 27 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/dct1d_rr_sched.sv | 116 +++++++++++
 4 files changed

// File: rtl/dct1d_pkg.sv
// Shared constants for the 8-point 1D DCT row scheduler.
// The optional grant statistics (macro DCT1D_SCHED_STATS_EN) are built in the top module.
package dct1d_pkg;

    localparam int N_PTS     = 8;
    localparam int IN_W      = 8;
    localparam int OUT_W     = 18;
    localparam int VEC_IN_W  = N_PTS * IN_W;   // 64
    localparam int VEC_OUT_W = N_PTS * OUT_W;  // 144

    // The requester tag is never narrower than one bit, even for two requesters.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dct1d_rr_sched_if.sv
// Request/result bus of the DCT row scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface dct1d_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int TAGW = dct1d_pkg::tag_width(NREQ)
);
    import dct1d_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*VEC_IN_W-1:0] req_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [VEC_OUT_W-1:0]     out_data;
    logic [TAGW-1:0]          out_tag;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_tag
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr (with wrap)
// whenever en is high, then moves rr_ptr just past the winner.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int TAGW = dct1d_pkg::tag_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [TAGW-1:0] grant_idx
);

    logic [TAGW-1:0] rr_ptr;
    logic [TAGW-1:0] hi_idx;
    logic [TAGW-1:0] lo_idx;
    logic            hi_hit;
    logic            lo_hit;

    // Priority search: lowest requester at/above rr_ptr, else lowest overall (the wrap).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hi_idx    = '0;
        lo_idx    = '0;
        hi_hit    = 1'b0;
        lo_hit    = 1'b0;
        grant     = '0;
        grant_idx = '0;
        // Descending scan so the last hit written is the lowest index.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = TAGW'(i);
                lo_hit = 1'b1;
                if (TAGW'(i) >= rr_ptr) begin
                    hi_idx = TAGW'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        if (en && lo_hit) begin
            grant_idx = hi_hit ? hi_idx : lo_idx;
            grant     = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    // Pointer moves one past the winner on a grant and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (grant_idx == TAGW'(NREQ - 1)) ? '0 : grant_idx + TAGW'(1);
        end
    end

endmodule

// File: rtl/dct1d_rr_sched.sv
// Shares one combinational 8-point DCT core among NREQ row requesters.
// Stage A registers the granted operand (core_x); stage B registers the core
// result with its requester tag and holds it under backpressure.
// Optional: DCT1D_SCHED_STATS_EN adds per-requester saturating grant counters.
module dct1d_rr_sched
    import dct1d_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = tag_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    dct1d_rr_sched_if.slave      bus,
    output logic [VEC_IN_W-1:0]  core_x,
    input  logic [VEC_OUT_W-1:0] core_y,
    output logic                 busy
`ifdef DCT1D_SCHED_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [NREQ*16-1:0]   grant_cnt
`endif
);

    logic                a_valid;
    logic [TAGW-1:0]     a_tag;
    logic                b_valid;
    logic                b_free;
    logic                a_adv;
    logic                a_load;
    logic                arb_en;
    logic                grant_any;
    logic [NREQ-1:0]     grant;
    logic [TAGW-1:0]     grant_idx;
    logic [VEC_IN_W-1:0] req_vec [NREQ];

    // Stage B can take a new result if empty or being drained this cycle.
    assign b_free    = !b_valid || bus.out_ready;
    assign a_adv     = a_valid && b_free;
    assign a_load    = !a_valid || a_adv;
    // No grants are offered while reset is held.
    assign arb_en    = a_load && !rst;
    assign grant_any = |grant;

    assign bus.req_ready = grant;
    assign bus.out_valid = b_valid;
    assign busy          = a_valid || b_valid;

    // Unpack the flat operand bus into one row per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_vec[i] = bus.req_data[VEC_IN_W*i +: VEC_IN_W];
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stage A: capture the granted operand, or empty out when it moves on ungranted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so core_x/out_data read as zero after reset.
            a_valid <= 1'b0;
            a_tag   <= '0;
            core_x  <= '0;
        end else if (grant_any) begin
            a_valid <= 1'b1;
            a_tag   <= grant_idx;
            core_x  <= req_vec[grant_idx];
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    // Stage B: capture the core result on advance; hold it stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid      <= 1'b0;
            bus.out_data <= '0;
            bus.out_tag  <= '0;
        end else if (a_adv) begin
            b_valid      <= 1'b1;
            bus.out_data <= core_y;
            bus.out_tag  <= a_tag;
        end else if (bus.out_ready) begin
            b_valid      <= 1'b0;
        end
    end

`ifdef DCT1D_SCHED_STATS_EN
    logic [15:0] cnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        // Saturating grant counter; clear wins over a same-cycle grant.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (stats_clr) begin
                cnt[i] <= '0;
            end else if (grant[i] && (cnt[i] != 16'hFFFF)) begin
                cnt[i] <= cnt[i] + 16'd1;
            end
        end
        assign grant_cnt[16*i +: 16] = cnt[i];
    end
`endif

endmodule
